// File: rtl/alu_pkg.sv
// ALU opcode encoding and retire-stage decode helpers.
package alu_pkg;

  localparam int unsigned CMD_W = 5;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD = 5'd0,
    CMD_SUB = 5'd1,
    CMD_AND = 5'd2,
    CMD_XOR = 5'd3,
    CMD_CMP = 5'd4,
    CMD_CEX = 5'd5,
    CMD_LSL = 5'd6,
    CMD_LSR = 5'd7,
    CMD_MOV = 5'd8
  } alu_cmd_t;

  // Ops that produce a register-file write (and refresh zero/parity flags).
  function automatic logic writes_reg(input logic [CMD_W-1:0] cmd);
    logic r;
    r = 1'b0;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_AND, CMD_XOR,
      CMD_LSL, CMD_LSR, CMD_MOV: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops whose shift/carry-out becomes the architectural carry flag.
  function automatic logic updates_sc(input logic [CMD_W-1:0] cmd);
    logic r;
    r = 1'b0;
    case (cmd)
      CMD_ADD, CMD_SUB, CMD_LSL, CMD_LSR: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Compare-class ops that resolve the condition flag.
  function automatic logic updates_cnd(input logic [CMD_W-1:0] cmd);
    logic r;
    r = 1'b0;
    case (cmd)
      CMD_CMP, CMD_CEX: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Registered writeback FIFO: push->head visible next cycle, flush clears
// occupancy and wins over any same-cycle push/pop. Head reads 0 when empty.
module wb_fifo #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 wr_data,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Status decoded from stored occupancy only; a pop frees its slot next cycle.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == CW'(0));
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rd_data = empty ? '0 : mem[rd_ptr];
  end

  // Storage write; pointers are power-of-two wide so they wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: architectural flags, writeback FIFO toward the
// register file, and a saturating retired-op counter.
// Optional feature macro: PARITY_FLAG_EN (adds the parity flag register).
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] alu_cmd,
  input  logic [AW-1:0]    dest,
  input  logic [DW-1:0]    rslt,
  input  logic             sc_o,
  input  logic             cnd,
  input  logic             zero,
  input  logic             pari,
  input  logic             flush,
  output logic             sc_q,
  output logic             cnd_q,
  output logic             zero_q,
  output logic             pari_q,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [AW-1:0]    wb_addr,
  output logic [DW-1:0]    wb_data,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned EW = DW + AW;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          accept;
  logic          push;
  logic          pop;
  logic [EW-1:0] fifo_wr_data;
  logic [EW-1:0] fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  // Handshake and opcode decode; ready depends only on stored FIFO state.
  always_comb begin
    in_ready     = (fifo_count != CW'(DEPTH));
    accept       = in_valid & ~fifo_full;
    push         = accept & writes_reg(alu_cmd);
    pop          = wb_valid & wb_ready;
    fifo_wr_data = {dest, rslt};
    wb_valid     = ~fifo_empty;
    wb_addr      = fifo_rd_data[DW +: AW];
    wb_data      = fifo_rd_data[DW-1:0];
  end

  wb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (fifo_wr_data),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Architectural carry/condition/zero flags, updated per opcode class on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_q   <= 1'b0;
      cnd_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      if (updates_sc(alu_cmd))  sc_q   <= sc_o;
      if (updates_cnd(alu_cmd)) cnd_q  <= cnd;
      if (writes_reg(alu_cmd))  zero_q <= zero;
    end
  end

`ifdef PARITY_FLAG_EN
  // Parity flag tracks the same ops as the zero flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pari_q <= 1'b0;
    end else if (accept && writes_reg(alu_cmd)) begin
      pari_q <= pari;
    end
  end
`else
  logic unused_pari;
  assign unused_pari = pari;
  assign pari_q      = 1'b0;
`endif

  // Retired-op counter, sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (accept && (retired != {CNT_W{1'b1}})) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; counter narrowed to 4 bits to reach saturation.
module tb_alu_result_stage;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned CNT_W = 4;
`ifdef PARITY_FLAG_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_cmd;
  logic [AW-1:0]    dest;
  logic [DW-1:0]    rslt;
  logic             sc_o, cnd, zero, pari, flush;
  logic             sc_q, cnd_q, zero_q, pari_q;
  logic             wb_valid, wb_ready;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic [CNT_W-1:0] retired;

  int total = 0;
  int bad   = 0;

  alu_result_stage #(.DW(DW), .AW(AW), .DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .dest(dest), .rslt(rslt), .sc_o(sc_o), .cnd(cnd),
    .zero(zero), .pari(pari), .flush(flush), .sc_q(sc_q), .cnd_q(cnd_q),
    .zero_q(zero_q), .pari_q(pari_q), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [4:0] c, input logic [3:0] d, input logic [7:0] r,
                    input logic s, input logic cn, input logic z, input logic p);
    in_valid = 1'b1;
    alu_cmd  = c;
    dest     = d;
    rslt     = r;
    sc_o     = s;
    cnd      = cn;
    zero     = z;
    pari     = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_cmd = '0; dest = '0; rslt = '0;
    sc_o = 1'b0; cnd = 1'b0; zero = 1'b0; pari = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    tick(); tick();
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_addr",  32'(wb_addr),  0);
    chk("rst_wb_data",  32'(wb_data),  0);
    chk("rst_flags",    32'({sc_q, cnd_q, zero_q, pari_q}), 0);
    chk("rst_retired",  32'(retired),  0);
    chk("rst_in_ready", 32'(in_ready), 1);
    reset = 1'b0;

    // 1: single ADD
    op(5'd0, 4'd3, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); in_valid = 1'b0;
    chk("t1_wb_valid", 32'(wb_valid), 1);
    chk("t1_wb_addr",  32'(wb_addr),  3);
    chk("t1_wb_data",  32'(wb_data),  32'h07);
    chk("t1_sc_q",     32'(sc_q),     0);
    chk("t1_pari_q",   32'(pari_q),   32'(PAR));
    chk("t1_retired",  32'(retired),  1);

    // 2: carry flag classes
    op(5'd0, 4'd1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_add_sc", 32'(sc_q), 1);
    chk("t2_pari_q", 32'(pari_q), 0);
    op(5'd6, 4'd2, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_lsl_sc",   32'(sc_q),    0);
    chk("t2_lsl_data", 32'(wb_data), 32'h55);
    op(5'd2, 4'd1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    op(5'd3, 4'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    op(5'd8, 4'd1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    chk("t2_logic_sc", 32'(sc_q), 0);
    chk("t2_retired",  32'(retired), 6);
    tick();

    // 3: condition/zero flags and undefined opcode
    op(5'd4, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    chk("t3_cmp_cnd",   32'(cnd_q),    1);
    chk("t3_cmp_nowb",  32'(wb_valid), 0);
    chk("t3_retired",   32'(retired),  7);
    op(5'd3, 4'd4, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t3_xor_zero",  32'(zero_q),   1);
    chk("t3_xor_cnd",   32'(cnd_q),    1);
    chk("t3_xor_wb",    32'(wb_valid), 1);
    op(5'd5, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t3_cex_cnd",   32'(cnd_q),    0);
    chk("t3_cex_zero",  32'(zero_q),   1);
    op(5'd20, 4'd9, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(); in_valid = 1'b0;
    chk("t3_undef_flags", 32'({sc_q, cnd_q, zero_q, pari_q}), 32'b0010);
    chk("t3_undef_nowb",  32'(wb_valid), 0);
    chk("t3_undef_ret",   32'(retired),  10);

    // 4: backpressure, full stall, in-order drain
    wb_ready = 1'b0;
    op(5'd0, 4'd5, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    op(5'd1, 4'd6, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("t4_full_ready", 32'(in_ready), 0);
    chk("t4_head_addr",  32'(wb_addr),  5);
    chk("t4_head_data",  32'(wb_data),  32'h11);
    op(5'd8, 4'd7, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t4_stall_ret",  32'(retired),  12);
    chk("t4_stall_rdy",  32'(in_ready), 0);
    wb_ready = 1'b1;
    tick();
    chk("t4_pop1_addr",  32'(wb_addr),  6);
    chk("t4_pop1_data",  32'(wb_data),  32'h22);
    chk("t4_pop1_rdy",   32'(in_ready), 1);
    chk("t4_pop1_ret",   32'(retired),  12);
    tick(); in_valid = 1'b0;
    chk("t4_pop2_addr",  32'(wb_addr),  7);
    chk("t4_pop2_data",  32'(wb_data),  32'h33);
    chk("t4_pop2_ret",   32'(retired),  13);
    tick();
    chk("t4_drained",    32'(wb_valid), 0);

    // 5: flush beats same-cycle push; flags and counter still update
    wb_ready = 1'b0;
    op(5'd2, 4'd8, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("t5_one_entry", 32'(wb_valid), 1);
    flush = 1'b1;
    op(5'd8, 4'd9, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("t5_flush_wb",   32'(wb_valid), 0);
    chk("t5_flush_zero", 32'(zero_q),   1);
    chk("t5_flush_ret",  32'(retired),  15);
    chk("t5_flush_rdy",  32'(in_ready), 1);
    tick();
    chk("t5_dropped",    32'(wb_valid), 0);
    wb_ready = 1'b1;
    op(5'd8, 4'd10, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t5_post_addr", 32'(wb_addr), 10);
    chk("t5_post_data", 32'(wb_data), 32'h77);
    chk("t5_saturate",  32'(retired), 15);

    // 6: async reset while full
    op(5'd4, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    wb_ready = 1'b0;
    op(5'd0, 4'd11, 8'h88, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    op(5'd1, 4'd12, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    in_valid = 1'b0;
    chk("t6_full",     32'(in_ready), 0);
    chk("t6_flags",    32'({sc_q, cnd_q, pari_q}), 32'({1'b1, 1'b1, PAR}));
    chk("t6_sat_hold", 32'(retired),  15);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_wb",      32'(wb_valid), 0);
    chk("t6_rst_flags",   32'({sc_q, cnd_q, zero_q, pari_q}), 0);
    chk("t6_rst_retired", 32'(retired),  0);
    chk("t6_rst_ready",   32'(in_ready), 1);
    #1;
    reset = 1'b0;
    tick();
    chk("t6_after_rst", 32'(wb_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
